// File: rtl/sdram_test_pkg.sv
// Shared types and the data-pattern function for the SDRAM traffic checker.
// The pattern function is also meant for bench scoreboards.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_WR_ISSUE  = 3'd2,
    ST_WR_WAIT   = 3'd3,
    ST_RD_ISSUE  = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_XOR  = 2'd2;

  // Callers pass the address zero-extended and keep the low DATA_WIDTH bits.
  function automatic logic [63:0] pattern(input logic [63:0] addr,
                                          input logic [1:0]  mode,
                                          input logic [63:0] seed);
    case (mode)
      PAT_INV: pattern = ~addr;
      PAT_XOR: pattern = addr ^ seed;
      default: pattern = addr;
    endcase
  endfunction

endpackage

// File: rtl/sdram_traffic_checker_burst_compare.sv
// Combinational per-lane compare of one read burst against its expected words:
// mismatch mask, number of mismatching lanes and the lowest mismatching lane.
module burst_compare #(
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 8,
  localparam int CNT_W  = $clog2(BURST_LENGTH) + 1,
  localparam int LANE_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1
) (
  input  logic [DATA_WIDTH*BURST_LENGTH-1:0] burst,
  input  logic [DATA_WIDTH*BURST_LENGTH-1:0] expected,
  output logic [BURST_LENGTH-1:0]            mismatch,
  output logic [CNT_W-1:0]                   mismatch_count,
  output logic [LANE_W-1:0]                  lowest_index
);

  // Lane compare and popcount.
  always_comb begin
    mismatch       = '0;
    mismatch_count = '0;
    for (int i = 0; i < BURST_LENGTH; i++) begin
      mismatch[i]    = (burst[i*DATA_WIDTH +: DATA_WIDTH] != expected[i*DATA_WIDTH +: DATA_WIDTH]);
      mismatch_count = mismatch_count + CNT_W'(mismatch[i]);
    end
  end

  // Scanning downwards leaves the lowest mismatching lane as the final value.
  always_comb begin
    lowest_index = '0;
    for (int i = BURST_LENGTH - 1; i >= 0; i--) begin
      if (mismatch[i]) begin
        lowest_index = LANE_W'(i);
      end else begin
        lowest_index = lowest_index;
      end
    end
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// Traffic generator/checker for sdram_burst port 0: writes an address-derived
// pattern over a region word by word, reads it back in bursts and reports.
module sdram_traffic_checker
  import sdram_test_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 25,
  parameter int          DATA_WIDTH     = 16,
  parameter int          BURST_LENGTH   = 8,
  parameter int          TEST_WORDS     = 256,
  parameter int          BASE_ADDR      = 0,
  parameter int          PATTERN        = 0,
  parameter logic [63:0] SEED           = 64'h0000_0000_0000_A5A5,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               init_complete,
  output logic [ADDR_WIDTH-1:0]              p0_addr,
  output logic [DATA_WIDTH-1:0]              p0_data,
  output logic [1:0]                         p0_byte_en,
  output logic                               p0_wr_req,
  output logic                               p0_rd_req,
  input  logic                               p0_available,
  input  logic                               p0_ready,
  input  logic [DATA_WIDTH*BURST_LENGTH-1:0] p0_q,
  output logic                               busy,
  output logic                               done,
  output logic                               pass,
  output logic                               timeout,
  output logic [15:0]                        error_count,
  output logic [ADDR_WIDTH-1:0]              first_error_addr
);

  localparam int         IDX_W    = $clog2(TEST_WORDS) + 1;
  localparam int         TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         CNT_W    = $clog2(BURST_LENGTH) + 1;
  localparam int         LANE_W   = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam logic [1:0] MODE     = 2'(PATTERN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [TMO_W-1:0]                  tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             data_q, data_d;
  logic [1:0]                        byte_en_q, byte_en_d;
  logic                              wr_req_q, wr_req_d;
  logic                              rd_req_q, rd_req_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic                              pass_q, pass_d;
  logic                              timeout_q, timeout_d;
  logic [15:0]                       err_q, err_d;
  logic [ADDR_WIDTH-1:0]             first_err_q, first_err_d;

  logic [ADDR_WIDTH-1:0]             issue_addr_s;
  logic [IDX_W-1:0]                  idx_inc_s;
  logic [IDX_W-1:0]                  idx_burst_s;
  logic [16:0]                       err_sum_s;
  logic [DATA_WIDTH*BURST_LENGTH-1:0] exp_burst_s;
  logic [BURST_LENGTH-1:0]           mismatch_s;
  logic [CNT_W-1:0]                  mm_count_s;
  logic [LANE_W-1:0]                 mm_lowest_s;

  assign issue_addr_s = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_q);
  assign idx_inc_s    = idx_q + IDX_W'(1);
  assign idx_burst_s  = idx_q + IDX_W'(BURST_LENGTH);
  assign err_sum_s    = {1'b0, err_q} + 17'(mm_count_s);

  // Expected words for the burst whose base address is held on p0_addr.
  always_comb begin
    exp_burst_s = '0;
    for (int i = 0; i < BURST_LENGTH; i++) begin
      exp_burst_s[i*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(pattern(64'(ADDR_WIDTH'(addr_q + ADDR_WIDTH'(i))), MODE, SEED));
    end
  end

  burst_compare #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BURST_LENGTH(BURST_LENGTH)
  ) u_cmp (
    .burst         (p0_q),
    .expected      (exp_burst_s),
    .mismatch      (mismatch_s),
    .mismatch_count(mm_count_s),
    .lowest_index  (mm_lowest_s)
  );

  // Run sequencing: write pass, read/compare pass, result and timeout handling.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    data_d      = data_q;
    byte_en_d   = byte_en_q;
    wr_req_d    = 1'b0;
    rd_req_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d       = 16'd0;
          first_err_d = '0;
          timeout_d   = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ST_WAIT_INIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_INIT: begin
        if (init_complete) begin
          state_d = ST_WR_ISSUE;
        end else begin
          state_d = ST_WAIT_INIT;
        end
      end
      ST_WR_ISSUE, ST_RD_ISSUE: begin
        if (p0_available) begin
          addr_d    = issue_addr_s;
          data_d    = DATA_WIDTH'(pattern(64'(issue_addr_s), MODE, SEED));
          byte_en_d = 2'b11;
          tmo_d     = '0;
          if (state_q == ST_WR_ISSUE) begin
            wr_req_d = 1'b1;
            state_d  = ST_WR_WAIT;
          end else begin
            rd_req_d = 1'b1;
            state_d  = ST_RD_WAIT;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WR_WAIT: begin
        if (p0_ready) begin
          byte_en_d = 2'b00;
          if (idx_inc_s == IDX_W'(TEST_WORDS)) begin
            idx_d   = '0;
            state_d = ST_RD_ISSUE;
          end else begin
            idx_d   = idx_inc_s;
            state_d = ST_WR_ISSUE;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          byte_en_d = 2'b00;
          state_d   = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RD_WAIT: begin
        if (p0_ready) begin
          byte_en_d = 2'b00;
          err_d     = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
          if ((err_q == 16'd0) && (|mismatch_s)) begin
            first_err_d = addr_q + ADDR_WIDTH'(mm_lowest_s);
          end else begin
            first_err_d = first_err_q;
          end
          if (idx_burst_s == IDX_W'(TEST_WORDS)) begin
            idx_d   = '0;
            pass_d  = (err_d == 16'd0);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_burst_s;
            state_d = ST_RD_ISSUE;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          byte_en_d = 2'b00;
          state_d   = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      byte_en_q   <= 2'b00;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 16'd0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      byte_en_q   <= byte_en_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
    end
  end

  assign p0_addr          = addr_q;
  assign p0_data          = data_q;
  assign p0_byte_en       = byte_en_q;
  assign p0_wr_req        = wr_req_q;
  assign p0_rd_req        = rd_req_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign timeout          = timeout_q;
  assign error_count      = err_q;
  assign first_error_addr = first_err_q;

endmodule
